// File: rtl/wrr_pkt_scheduler_if.sv
// Request/grant bundle between the output-queue read path and the WRR scheduler.
// Holds the per-queue requests, the weight programming strobe and the grant outputs.
interface wrr_pkt_scheduler_if #(
  parameter int ARB_NUM = 8,
  parameter int W       = 4
);
  localparam int IDX_W = $clog2(ARB_NUM);

  logic [ARB_NUM-1:0]   iReq;
  logic                 iDone;
  logic [ARB_NUM*W-1:0] iWeight;
  logic                 iWeightLoad;
  logic [ARB_NUM-1:0]   oGnt;
  logic                 oGntValid;
  logic [IDX_W-1:0]     oGntIdx;
  logic                 oRefresh;

  modport slave  (input iReq, iDone, iWeight, iWeightLoad,
                  output oGnt, oGntValid, oGntIdx, oRefresh);
  modport master (output iReq, iDone, iWeight, iWeightLoad,
                  input oGnt, oGntValid, oGntIdx, oRefresh);
endinterface

// File: rtl/wrr_pkt_scheduler.sv
// Packet-granular weighted round-robin scheduler: one grant held per packet,
// credits refilled from the weights once no requesting queue has credit left.
module wrr_pkt_scheduler #(
  parameter int WEIGHT_NUM = 8,
  parameter int ARB_NUM    = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  wrr_pkt_scheduler_if.slave bus
);
  localparam int W     = $clog2(WEIGHT_NUM) + 1;
  localparam int IDX_W = $clog2(ARB_NUM);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [ARB_NUM-1:0]        gnt_q, gnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      refresh_q, refresh_d;
  logic [ARB_NUM-1:0][W-1:0] weight_q, weight_d;
  logic [ARB_NUM-1:0][W-1:0] credit_q, credit_d;

  logic [ARB_NUM-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   cand;

  always_comb begin
    for (int i = 0; i < ARB_NUM; i++) elig[i] = bus.iReq[i] & (credit_q[i] != '0);
  end

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < ARB_NUM; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(ARB_NUM)) sum = sum - (IDX_W+1)'(ARB_NUM);
      cand = sum[IDX_W-1:0];
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    refresh_d = 1'b0;
    weight_d  = weight_q;
    credit_d  = credit_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          idx_d      = win;
          state_d    = BUSY;
          ptr_d      = (win == IDX_W'(ARB_NUM-1)) ? '0 : win + 1'b1;
          if (credit_q[win] != '0) credit_d[win] = credit_q[win] - W'(1);
        end else if (bus.iReq != '0) begin
          credit_d  = weight_q;
          refresh_d = 1'b1;
        end
      end
      BUSY: begin
        if (bus.iDone) begin
          gnt_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A load replaces both weight and credit; any same-cycle refill or decrement is lost.
    if (bus.iWeightLoad) begin
      for (int i = 0; i < ARB_NUM; i++) begin
        weight_d[i] = bus.iWeight[(ARB_NUM-1-i)*W +: W];
        credit_d[i] = bus.iWeight[(ARB_NUM-1-i)*W +: W];
      end
      refresh_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      refresh_q <= 1'b0;
      weight_q  <= '1;
      credit_q  <= '1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      refresh_q <= refresh_d;
      weight_q  <= weight_d;
      credit_q  <= credit_d;
    end
  end

  assign bus.oGnt      = gnt_q;
  assign bus.oGntValid = |gnt_q;
  assign bus.oGntIdx   = idx_q;
  assign bus.oRefresh  = refresh_q;
endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
// Bench for wrr_pkt_scheduler: directed scenarios plus random traffic, all cycles
// compared against a rule-level reference model of the credit/round-robin policy.
module tb_wrr_pkt_scheduler;
  localparam int N  = 4;
  localparam int WN = 8;
  localparam int W  = $clog2(WN) + 1;
  localparam int R  = 9;  // event code for a refresh pulse in the event log

  logic iClk = 1'b0;
  logic iRst;

  wrr_pkt_scheduler_if #(.ARB_NUM(N), .W(W)) bus();
  wrr_pkt_scheduler #(.WEIGHT_NUM(WN), .ARB_NUM(N)) dut (
    .iClk(iClk), .iRst(iRst), .bus(bus.slave));

  always #5 iClk = ~iClk;

  int checks = 0, errors = 0, cyc = 0;
  int m_w[N], m_c[N];
  int m_ptr, m_idx;
  bit m_busy, m_ref;
  int ev_q[$], ev_t[$], exp_q[$];
  logic prev_valid = 1'b0;
  int bcnt = 0;
  bit auto_done = 1'b1;

  function automatic logic [N*W-1:0] pack(input int w0, input int w1, input int w2, input int w3);
    return {W'(w0), W'(w1), W'(w2), W'(w3)};
  endfunction

  task automatic model_tick();
    int win;
    logic [N-1:0] req;
    req = bus.iReq;
    if (iRst) begin
      m_busy = 0; m_ptr = 0; m_idx = 0; m_ref = 0;
      for (int i = 0; i < N; i++) begin m_w[i] = 2**W - 1; m_c[i] = 2**W - 1; end
      return;
    end
    m_ref = 0;
    win = -1;
    if (m_busy) begin
      if (bus.iDone) begin m_busy = 0; m_idx = 0; end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && req[j] && m_c[j] > 0) win = j;
      end
      if (win >= 0) begin
        m_busy = 1; m_idx = win; m_ptr = (win + 1) % N; m_c[win] = m_c[win] - 1;
      end else if (req != 0) begin
        for (int i = 0; i < N; i++) m_c[i] = m_w[i];
        m_ref = 1;
      end
    end
    if (bus.iWeightLoad) begin
      for (int i = 0; i < N; i++) begin
        m_w[i] = int'(bus.iWeight[(N-1-i)*W +: W]);
        m_c[i] = m_w[i];
      end
      m_ref = 0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, one;
    one = 1;
    eg = m_busy ? (one << m_idx) : '0;
    checks++;
    assert (bus.oGnt === eg) else begin
      errors++; $error("FAIL gnt cyc=%0d obs=%b exp=%b", cyc, bus.oGnt, eg);
    end
    checks++;
    assert (bus.oGntValid === m_busy) else begin
      errors++; $error("FAIL gnt_valid cyc=%0d obs=%b exp=%b", cyc, bus.oGntValid, m_busy);
    end
    checks++;
    assert (bus.oRefresh === m_ref) else begin
      errors++; $error("FAIL refresh cyc=%0d obs=%b exp=%b", cyc, bus.oRefresh, m_ref);
    end
    if (m_busy) begin
      checks++;
      assert (int'(bus.oGntIdx) === m_idx) else begin
        errors++; $error("FAIL gnt_idx cyc=%0d obs=%0d exp=%0d", cyc, bus.oGntIdx, m_idx);
      end
    end
    if (bus.oGntValid === 1'b1 && prev_valid !== 1'b1) begin
      ev_q.push_back(int'(bus.oGntIdx)); ev_t.push_back(cyc);
    end
    if (bus.oRefresh === 1'b1) begin
      ev_q.push_back(R); ev_t.push_back(cyc);
    end
    prev_valid = bus.oGntValid;
  endtask

  task automatic cycle();
    if (auto_done) begin
      if (m_busy) begin bcnt++; bus.iDone = (bcnt == 2); end
      else begin bcnt = 0; bus.iDone = 1'b0; end
    end
    @(posedge iClk);
    model_tick();
    @(negedge iClk);
    cyc++;
    check_outputs();
  endtask

  task automatic run_events(input string tag, input int n, input int budget);
    int b;
    ev_q.delete(); ev_t.delete();
    b = 0;
    while (ev_q.size() < n && b < budget) begin cycle(); b++; end
    checks++;
    assert (ev_q.size() >= n) else begin
      errors++; $error("FAIL %s_timeout events=%0d need=%0d", tag, ev_q.size(), n);
    end
  endtask

  task automatic expect_seq(input string tag);
    int got;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      checks++;
      assert (got === exp_q[i]) else begin
        errors++; $error("FAIL %s_ev%0d obs=%0d exp=%0d", tag, i, got, exp_q[i]);
      end
    end
  endtask

  task automatic load_weights(input logic [N*W-1:0] wv);
    bus.iWeight = wv; bus.iWeightLoad = 1'b1;
    cycle();
    bus.iWeightLoad = 1'b0;
  endtask

  initial begin
    int cnt[N];
    iRst = 1'b1;
    bus.iReq = '0; bus.iDone = 1'b0; bus.iWeight = '0; bus.iWeightLoad = 1'b0;

    // 1: reset and idle with no requests
    repeat (2) cycle();
    iRst = 1'b0;
    repeat (4) cycle();
    checks++;
    assert (bus.oGnt === '0 && bus.oGntIdx === '0 && bus.oRefresh === 1'b0) else begin
      errors++; $error("FAIL reset_idle obs=%b/%0d/%b exp=0/0/0", bus.oGnt, bus.oGntIdx, bus.oRefresh);
    end

    // 2: weights {2,1,1,1}, all requesting
    load_weights(pack(2, 1, 1, 1));
    bus.iReq = 4'hF;
    run_events("t2", 12, 100);
    exp_q = '{0, 1, 2, 3, 0, R, 1, 2, 3, 0, 0, R};
    expect_seq("t2");

    // 3: zero weight on q0
    bus.iReq = '0;
    cycle();
    load_weights(pack(0, 1, 1, 1));
    bus.iReq = 4'hF;
    run_events("t3", 8, 100);
    exp_q = '{1, 2, 3, R, 1, 2, 3, R};
    expect_seq("t3");

    // 4: single requester with weight 1: done -> refresh -> grant spacing
    bus.iReq = '0;
    load_weights(pack(1, 1, 1, 1));
    bus.iReq = 4'b0100;
    run_events("t4", 5, 100);
    exp_q = '{2, R, 2, R, 2};
    expect_seq("t4");
    checks++;
    assert (ev_t.size() >= 3 && ev_t[1] - ev_t[0] == 3 && ev_t[2] - ev_t[0] == 4) else begin
      errors++; $error("FAIL t4_spacing obs=%0d,%0d exp=3,4",
                       (ev_t.size() >= 2) ? ev_t[1] - ev_t[0] : -1,
                       (ev_t.size() >= 3) ? ev_t[2] - ev_t[0] : -1);
    end

    // 5: weight load while BUSY on q1
    bus.iReq = '0;
    cycle(); cycle();
    auto_done = 1'b0; bus.iDone = 1'b0;
    bus.iReq = 4'b0010;
    cycle();
    load_weights(pack(3, 2, 5, 7));
    cycle(); cycle();
    checks++;
    assert (bus.oGnt === 4'b0010) else begin
      errors++; $error("FAIL t5_hold obs=%b exp=0010", bus.oGnt);
    end
    bus.iDone = 1'b1;
    cycle();
    bus.iDone = 1'b0; auto_done = 1'b1;
    bus.iReq = 4'hF;
    run_events("t5", 18, 200);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < 17 && i < ev_q.size(); i++) if (ev_q[i] < N) cnt[ev_q[i]]++;
    exp_q = '{3, 2, 5, 7};
    for (int i = 0; i < N; i++) begin
      checks++;
      assert (cnt[i] === exp_q[i]) else begin
        errors++; $error("FAIL t5_credit_q%0d obs=%0d exp=%0d", i, cnt[i], exp_q[i]);
      end
    end
    checks++;
    assert (ev_q.size() >= 18 && ev_q[17] === R) else begin
      errors++; $error("FAIL t5_refresh obs=%0d exp=%0d", (ev_q.size() >= 18) ? ev_q[17] : -1, R);
    end

    // 6: reset in the middle of a packet
    run_events("t6a", 1, 20);
    if (!m_busy) run_events("t6b", 1, 20);
    iRst = 1'b1;
    cycle();
    checks++;
    assert (bus.oGnt === '0) else begin
      errors++; $error("FAIL t6_rst_drop obs=%b exp=0000", bus.oGnt);
    end
    iRst = 1'b0;
    bus.iReq = 4'b0110;
    run_events("t6c", 1, 10);
    checks++;
    assert (ev_q.size() >= 1 && ev_q[0] === 1) else begin
      errors++; $error("FAIL t6_first obs=%0d exp=1", (ev_q.size() >= 1) ? ev_q[0] : -1);
    end

    // random traffic with loads (including zero weights) issued while busy
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) bus.iReq = N'($urandom_range(0, 15));
      if (m_busy && $urandom_range(0, 19) == 0) begin
        bus.iWeight = pack($urandom_range(0, 8), $urandom_range(0, 8),
                           $urandom_range(0, 8), $urandom_range(0, 8));
        bus.iWeightLoad = 1'b1;
      end else begin
        bus.iWeightLoad = 1'b0;
      end
      cycle();
    end
    bus.iWeightLoad = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
